seg_scan_controller: RTL and testbench
======================================

// Module: seg_scan_controller
// PURPOSE
//  Time-multiplexed scan controller for the 3-digit seven-segment display of a 10-bit value.
//  Shares one SevSegDriver instance across the three digits and drives active-low anodes.
//  Cycles digit slots with dead time, applies optional leading-zero blanking, and takes new
//  values over a valid/ready handshake, applying them only at frame boundaries (no tearing).
// PARAMETERS
//  TICK_DIV   50000  clock cycles per digit slot; legal range >= 2
//  BLANK_CYC  16     dead-time cycles at the start of each slot with all anodes off; < TICK_DIV
//  LZ_BLANK   1      1 = blank leading-zero digits 2 and 1; 0 = always show all three digits
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  en         in   1   display enable; 0 forces all anodes off, scanning continues
//  in_value   in   10  value to display; digit0 = [3:0], digit1 = [7:4], digit2 = {2'b00,[9:8]}
//  in_valid   in   1   in_value is valid this cycle
//  in_ready   out  1   controller can accept a value (= !pend_vld)
//  seg        out  7   segment pattern from the internal SevSegDriver, fed by the registered nibble
//  an_n       out  3   active-low digit enables; an_n[d] = 0 lights digit d
//  frame_done out  1   one-cycle pulse at the end of every digit-2 slot
// BEHAVIOUR
//  Reset (async):
//   - cnt = 0, digit = 0, disp = 0, pend = 0, pend_vld = 0, nibble = 0, frame_done = 0.
//   - Outputs: an_n = 3'b111, in_ready = 1, seg = SevSegDriver(4'h0).
//  Slot counter:
//   - cnt counts 0 .. TICK_DIV-1 and then wraps to 0.
//   - On wrap, digit advances 0 -> 1 -> 2 -> 0. There are no other states; en does not stall it.
//  Nibble:
//   - Registered: on the cycle cnt wraps, nibble loads the next digit's nibble from disp.
//   - nibble is therefore valid for the whole slot.
//  Anodes:
//   - Combinational from registers only.
//   - an_n[d] = 0 iff en && digit == d && cnt >= BLANK_CYC && !blank(d).
//   - At most one anode is low at any time.
//  Leading-zero blanking (LZ_BLANK = 1):
//   - blank(2) = (disp[9:8] == 0).
//   - blank(1) = blank(2) && (disp[7:4] == 0).
//   - blank(0) = 0: value 0 shows a single "0".
//  Handshake:
//   - Accept occurs when in_valid && in_ready: pend <= in_value, pend_vld <= 1.
//   - in_ready is low while pend_vld = 1; in_value is ignored then. Latest-accepted wins only
//     via re-handshake.
//  Frame commit:
//   - Frame end occurs when digit == 2 && cnt == TICK_DIV-1.
//   - At frame end: frame_done = 1 the next cycle (registered pulse).
//   - At frame end, if pend_vld: disp <= pend, pend_vld <= 0.
//   - The new value is first shown in the digit-0 slot that begins next.
//  Simultaneous events:
//   - An accept in the frame-end cycle (pend_vld = 0 then) is not committed in that cycle.
//     It commits at the following frame end.
//   - No accept can coincide with a commit, because in_ready = 0 whenever pend_vld = 1.
//  Reset mid-frame:
//   - All state clears immediately, including any pending value (dropped).
//   - Scan restarts at digit 0, cnt 0.
//  Timing:
//   - Refresh period = 3*TICK_DIV cycles.
//   - Worst-case latency from accept to visible = 3*TICK_DIV + BLANK_CYC + 1 cycles.
// TESTING  (TICK_DIV = 8, BLANK_CYC = 2, LZ_BLANK = 1 unless noted)
//  1. Hold rst = 1, then release -> an_n = 111 and in_ready = 1 immediately.
//     Then an_n = 110 for cnt 2..7 of slot 0; an_n = 111 in slots 1/2; seg = "0" pattern.
//  2. Accept 10'h2A5 mid-frame -> in_ready = 0 next cycle; disp unchanged until frame_done.
//     Then slots show 5, A, 2 with an_n = 110/101/011; in_ready returns to 1.
//  3. LZ_BLANK = 0, value 10'h005 -> all three digits lit, showing 0, 0, 5.
//     With LZ_BLANK = 1, value 10'h0A5 -> digit 2 dark, digits 1/0 lit.
//  4. in_valid held high while pend_vld = 1 with changing in_value -> only the first accepted
//     value is displayed.
//     Accept in the exact frame-end cycle -> displayed one frame later.
//  5. en = 0 for one full frame -> an_n = 111 throughout; frame_done still pulses every 24 cycles.
//     Commit still happens.
//  6. Assert rst mid-slot with a pending value -> an_n = 111 asynchronously (before next edge).
//     Pending value lost; display restarts showing 0.

Source files
------------

// File: rtl/seg_scan_controller.sv
`timescale 1ns/1ps
// Hex nibble to seven-segment pattern, seg_o = {g,f,e,d,c,b,a}, active-high.
// Purely combinational; no flow control.
module sev_seg_driver (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = 7'h00;
        case (nibble_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = 7'h00;
        endcase
    end
endmodule

// Three-digit multiplexed seven-segment scanner with dead time and leading-zero blanking.
// Accepted value shows within 3*TICK_DIV+BLANK_CYC+1 cycles; in_ready drops while one value is pending.
module seg_scan_controller #(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 16,
    parameter bit LZ_BLANK  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [9:0] in_value,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [6:0] seg,
    output logic [2:0] an_n,
    output logic       frame_done
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    typedef enum logic [1:0] {DIG0 = 2'd0, DIG1 = 2'd1, DIG2 = 2'd2} digit_e;

    digit_e           digit_q, digit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       disp_q, disp_d;
    logic [9:0]       pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [3:0]       nibble_q, nibble_d;
    logic             frame_done_q;
    logic             slot_end, frame_end, accept;
    logic             blank1, blank2;

    assign slot_end   = (cnt_q == CNT_LAST);
    assign frame_end  = slot_end && (digit_q == DIG2);
    assign in_ready   = !pend_vld_q;
    assign accept     = in_valid && in_ready;
    assign frame_done = frame_done_q;

    assign blank2 = LZ_BLANK && (disp_q[9:8] == 2'b00);
    assign blank1 = blank2 && (disp_q[7:4] == 4'h0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= DIG0;
        end else begin
            digit_q <= digit_d;
        end
    end

    always_comb begin
        digit_d = digit_q;
        if (slot_end) begin
            case (digit_q)
                DIG0:    digit_d = DIG1;
                DIG1:    digit_d = DIG2;
                default: digit_d = DIG0;
            endcase
        end
    end

    always_comb begin
        cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        // Commit and accept are exclusive: accept needs pend_vld_q low, commit needs it high.
        if (frame_end && pend_vld_q) begin
            disp_d     = pend_q;
            pend_vld_d = 1'b0;
        end else if (accept) begin
            pend_d     = in_value;
            pend_vld_d = 1'b1;
        end
        // Load from disp_d so a value committed at frame end is what digit 0 shows next.
        nibble_d = nibble_q;
        if (slot_end) begin
            case (digit_d)
                DIG1:    nibble_d = disp_d[7:4];
                DIG2:    nibble_d = {2'b00, disp_d[9:8]};
                default: nibble_d = disp_d[3:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            nibble_q     <= 4'h0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            nibble_q     <= nibble_d;
            frame_done_q <= frame_end;
        end
    end

    always_comb begin
        an_n = 3'b111;
        if (en && (cnt_q >= BLANK_END)) begin
            case (digit_q)
                DIG0:    an_n[0] = 1'b0;
                DIG1:    an_n[1] = blank1;
                DIG2:    an_n[2] = blank2;
                default: an_n    = 3'b111;
            endcase
        end
    end

    sev_seg_driver u_sev_seg (
        .nibble_i (nibble_q),
        .seg_o    (seg)
    );
endmodule

// File: tb/tb_seg_scan_controller.sv
`timescale 1ns/1ps
// Directed bench for seg_scan_controller at TICK_DIV=8, BLANK_CYC=2, with and without blanking.
module tb_seg_scan_controller;
    localparam int TD = 8;
    localparam int BC = 2;
    localparam int FR = 3 * TD;

    logic       clk = 1'b0;
    logic       rst, en, in_valid;
    logic [9:0] in_value;
    logic [6:0] seg0, seg1;
    logic [2:0] an0, an1;
    logic       rdy0, rdy1, fd0, fd1;
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seg_scan_controller #(.TICK_DIV(TD), .BLANK_CYC(BC), .LZ_BLANK(1'b1)) u_lz (
        .clk(clk), .rst(rst), .en(en), .in_value(in_value), .in_valid(in_valid),
        .in_ready(rdy0), .seg(seg0), .an_n(an0), .frame_done(fd0)
    );

    seg_scan_controller #(.TICK_DIV(TD), .BLANK_CYC(BC), .LZ_BLANK(1'b0)) u_nolz (
        .clk(clk), .rst(rst), .en(en), .in_value(in_value), .in_valid(in_valid),
        .in_ready(rdy1), .seg(seg1), .an_n(an1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] nib_of(input logic [9:0] v, input int d);
        if (d == 2) return {2'b00, v[9:8]};
        if (d == 1) return v[7:4];
        return v[3:0];
    endfunction

    function automatic logic [2:0] an_exp(input logic [9:0] v, input bit lz, input bit e, input int k);
        int d = (k / TD) % 3;
        int c = k % TD;
        bit b2 = lz && (v[9:8] == 2'b00);
        bit b1 = b2 && (v[7:4] == 4'h0);
        bit bl = (d == 2) ? b2 : ((d == 1) ? b1 : 1'b0);
        logic [2:0] a = 3'b111;
        if (e && c >= BC && !bl) a[d] = 1'b0;
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic goto_pos(input int p);
        for (int i = 0; i < FR && (cyc % FR) != p; i++) step();
    endtask

    // Checks both instances for n cycles against value v, starting at the current position.
    task automatic run_checks(input logic [9:0] v, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            logic [2:0] e0, e1;
            logic [6:0] es;
            logic       ef;
            e0 = an_exp(v, 1'b1, en, cyc);
            e1 = an_exp(v, 1'b0, en, cyc);
            es = seg_of(nib_of(v, (cyc / TD) % 3));
            ef = ((cyc % FR) == 0) && (cyc != 0);
            total++; if (an0 !== e0) begin bad++; $display("FAIL %s an_n_lz cyc=%0d got=%b exp=%b", tag, cyc, an0, e0); end
            total++; if (an1 !== e1) begin bad++; $display("FAIL %s an_n_nolz cyc=%0d got=%b exp=%b", tag, cyc, an1, e1); end
            total++; if (seg0 !== es) begin bad++; $display("FAIL %s seg_lz cyc=%0d got=%h exp=%h", tag, cyc, seg0, es); end
            total++; if (seg1 !== es) begin bad++; $display("FAIL %s seg_nolz cyc=%0d got=%h exp=%h", tag, cyc, seg1, es); end
            total++; if (fd0 !== ef) begin bad++; $display("FAIL %s frame_done_lz cyc=%0d got=%b exp=%b", tag, cyc, fd0, ef); end
            total++; if (fd1 !== ef) begin bad++; $display("FAIL %s frame_done_nolz cyc=%0d got=%b exp=%b", tag, cyc, fd1, ef); end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_value = 10'h000;
        repeat (3) @(negedge clk);
        total++; if (an0 !== 3'b111) begin bad++; $display("FAIL rst_an_n got=%b exp=111", an0); end
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", rdy0); end
        total++; if (seg0 !== 7'h3F) begin bad++; $display("FAIL rst_seg got=%h exp=3f", seg0); end
        total++; if (fd0 !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b exp=0", fd0); end
        rst = 1'b0;
        cyc = 0;
        #1;
        total++; if (an0 !== 3'b111) begin bad++; $display("FAIL release_an_n got=%b exp=111", an0); end
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", rdy0); end
        run_checks(10'h000, FR, "reset_frame");
    endtask

    task automatic test_accept();
        goto_pos(10);
        in_value = 10'h2A5; in_valid = 1'b1;
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL acc_ready_before got=%b exp=1", rdy0); end
        step();
        in_valid = 1'b0; in_value = 10'h000;
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL acc_ready_low got=%b exp=0", rdy0); end
        run_checks(10'h000, FR - 11, "acc_pre_commit");
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL acc_ready_back got=%b exp=1", rdy0); end
        run_checks(10'h2A5, FR, "acc_show_2a5");
    endtask

    task automatic accept_at_start(input logic [9:0] v);
        goto_pos(0);
        in_value = v; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        goto_pos(0);
    endtask

    task automatic test_lz();
        accept_at_start(10'h005);
        run_checks(10'h005, FR, "lz_005");
        accept_at_start(10'h0A5);
        run_checks(10'h0A5, FR, "lz_0a5");
    endtask

    task automatic test_hold_and_frame_end();
        goto_pos(3);
        in_value = 10'h111; in_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            in_value = 10'h200 + 10'(i);
            total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL hold_ready i=%0d got=%b exp=0", i, rdy0); end
            step();
        end
        in_valid = 1'b0;
        goto_pos(0);
        run_checks(10'h111, FR, "hold_first_wins");
        goto_pos(FR - 1);
        in_value = 10'h3C7; in_valid = 1'b1;
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL fe_ready_before got=%b exp=1", rdy0); end
        step();
        in_valid = 1'b0;
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL fe_pending got=%b exp=0", rdy0); end
        run_checks(10'h111, FR, "fe_old_frame");
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL fe_committed_ready got=%b exp=1", rdy0); end
        run_checks(10'h3C7, FR, "fe_new_frame");
    endtask

    task automatic test_enable();
        goto_pos(0);
        en = 1'b0;
        in_value = 10'h155; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        run_checks(10'h3C7, FR - 1, "en_off_old");
        run_checks(10'h155, FR, "en_off_new");
        en = 1'b1;
        run_checks(10'h155, FR, "en_on");
    endtask

    task automatic test_reset_mid();
        goto_pos(12);
        in_value = 10'h3FF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (an0 !== 3'b101) begin bad++; $display("FAIL mid_an_n_before got=%b exp=101", an0); end
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL mid_pending got=%b exp=0", rdy0); end
        #2 rst = 1'b1;
        #1;
        total++; if (an0 !== 3'b111) begin bad++; $display("FAIL mid_async_an_n got=%b exp=111", an0); end
        total++; if (an1 !== 3'b111) begin bad++; $display("FAIL mid_async_an_n_nolz got=%b exp=111", an1); end
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL mid_async_ready got=%b exp=1", rdy0); end
        total++; if (seg0 !== 7'h3F) begin bad++; $display("FAIL mid_async_seg got=%h exp=3f", seg0); end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        run_checks(10'h000, 2 * FR, "mid_restart");
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL mid_ready_after got=%b exp=1", rdy0); end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_lz();
        test_hold_and_frame_end();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
